// File: rtl/uart_baud_frac.sv
// Fractional-divider UART baud generator: shared oversample prescaler feeding
// independent TX (bit boundary) and RX (mid-bit) phase counters.
module uart_baud_frac #(
  parameter int DIV_W   = 12,
  parameter int FRAC_W  = 4,
  parameter int OSR     = 16,
  parameter int RST_INT = 339
) (
  input  logic              clk26m,
  input  logic              rstn,
  input  logic              tx_bps_en,
  input  logic              rx_bps_en,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              div_busy,
  output logic              rx_os_tick,
  output logic              rx_bpsclk,
  output logic              tx_bpsclk
);

  localparam int OS_W = $clog2(OSR);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OSR / 2 - 1);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RST_INT);

  function automatic logic [DIV_W:0] clamp_int(input logic [DIV_W-1:0] v);
    if (v < DIV_W'(2)) begin
      clamp_int = (DIV_W + 1)'(2);
    end else begin
      clamp_int = {1'b0, v};
    end
  endfunction

  logic [DIV_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  logic              r_pend;
  logic [DIV_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic              r_run;
  logic [DIV_W:0]    r_pcnt;
  logic [FRAC_W-1:0] r_facc;
  logic [OS_W-1:0]   r_tx_os;
  logic [OS_W-1:0]   r_rx_os;
  logic              r_tx_bpsclk;
  logic              r_rx_bpsclk;
  logic              r_rx_os_tick;

  logic              w_en_any;
  logic [FRAC_W:0]   w_fsum;
  logic [DIV_W:0]    w_per;
  logic              w_os;

  assign w_en_any = tx_bps_en | rx_bps_en;
  assign w_fsum   = {1'b0, r_facc} + {1'b0, r_act_frac};
  assign w_per    = clamp_int(r_act_int) + {{DIV_W{1'b0}}, w_fsum[FRAC_W]};
  // r_run keeps the first enabled cycle as a load cycle so a fresh start lasts a full P
  assign w_os     = w_en_any & r_run & (r_pcnt == (w_per - (DIV_W + 1)'(1)));

  // Divisor staging: writes land directly when idle, otherwise wait for both channels idle
  always_ff @(posedge clk26m or negedge rstn) begin
    if (!rstn) begin
      r_act_int   <= RST_DIV;
      r_act_frac  <= '0;
      r_pend      <= 1'b0;
      r_pend_int  <= '0;
      r_pend_frac <= '0;
    end else if (div_wr && !w_en_any) begin
      r_act_int   <= div_int;
      r_act_frac  <= div_frac;
      r_pend      <= 1'b0;
    end else if (div_wr) begin
      r_pend      <= 1'b1;
      r_pend_int  <= div_int;
      r_pend_frac <= div_frac;
    end else if (r_pend && !w_en_any) begin
      r_act_int   <= r_pend_int;
      r_act_frac  <= r_pend_frac;
      r_pend      <= 1'b0;
    end
  end

  // Shared prescaler with fractional accumulator
  always_ff @(posedge clk26m or negedge rstn) begin
    if (!rstn) begin
      r_run  <= 1'b0;
      r_pcnt <= '0;
      r_facc <= '0;
    end else begin
      r_run <= w_en_any;
      if (!w_en_any || !r_run) begin
        r_pcnt <= '0;
        if (!w_en_any) begin
          r_facc <= '0;
        end
      end else if (w_os) begin
        r_pcnt <= '0;
        r_facc <= w_fsum[FRAC_W-1:0];
      end else begin
        r_pcnt <= r_pcnt + (DIV_W + 1)'(1);
      end
    end
  end

  // Per-channel phase counters and registered strobes
  always_ff @(posedge clk26m or negedge rstn) begin
    if (!rstn) begin
      r_tx_os      <= '0;
      r_rx_os      <= '0;
      r_tx_bpsclk  <= 1'b0;
      r_rx_bpsclk  <= 1'b0;
      r_rx_os_tick <= 1'b0;
    end else begin
      if (!tx_bps_en) begin
        r_tx_os <= '0;
      end else if (w_os) begin
        r_tx_os <= (r_tx_os == OS_LAST) ? '0 : r_tx_os + OS_W'(1);
      end
      if (!rx_bps_en) begin
        r_rx_os <= '0;
      end else if (w_os) begin
        r_rx_os <= (r_rx_os == OS_LAST) ? '0 : r_rx_os + OS_W'(1);
      end
      r_tx_bpsclk  <= w_os & tx_bps_en & (r_tx_os == OS_LAST);
      r_rx_bpsclk  <= w_os & rx_bps_en & (r_rx_os == OS_MID);
      r_rx_os_tick <= w_os & rx_bps_en;
    end
  end

  assign div_busy   = r_pend;
  assign tx_bpsclk  = r_tx_bpsclk;
  assign rx_bpsclk  = r_rx_bpsclk;
  assign rx_os_tick = r_rx_os_tick;

endmodule

// File: tb/tb_uart_baud_frac.sv
// Scoreboard bench for uart_baud_frac: expected strobe events are queued from a
// divisor model when stimulus is applied and compared against observed events.
module tb_uart_baud_frac;

  localparam int DIV_W  = 12;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;

  typedef struct packed {
    logic [1:0]  kind;   // 0 tx_bpsclk, 1 rx_bpsclk, 2 rx_os_tick, 3 none
    logic [31:0] cyc;
  } ev_t;

  logic              clk26m = 1'b0;
  logic              rstn = 1'b1;
  logic              tx_bps_en = 1'b0;
  logic              rx_bps_en = 1'b0;
  logic              div_wr = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_busy;
  logic              rx_os_tick;
  logic              rx_bpsclk;
  logic              tx_bpsclk;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  uart_baud_frac dut (
    .clk26m    (clk26m),
    .rstn      (rstn),
    .tx_bps_en (tx_bps_en),
    .rx_bps_en (rx_bps_en),
    .div_wr    (div_wr),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_busy  (div_busy),
    .rx_os_tick(rx_os_tick),
    .rx_bpsclk (rx_bpsclk),
    .tx_bpsclk (tx_bpsclk)
  );

  always #5 clk26m = ~clk26m;

  // cyc equals the index of the most recent rising edge
  always @(posedge clk26m) cyc <= cyc + 1;

  // Observed-event collector; same-cycle ordering is tx, rx, tick
  always @(negedge clk26m) begin
    if (tx_bpsclk)  obs_q.push_back({2'd0, 32'(cyc)});
    if (rx_bpsclk)  obs_q.push_back({2'd1, 32'(cyc)});
    if (rx_os_tick) obs_q.push_back({2'd2, 32'(cyc)});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk26m);
  endtask

  task automatic write_div(input int i, input int f);
    @(negedge clk26m);
    div_int  = DIV_W'(i);
    div_frac = FRAC_W'(f);
    div_wr   = 1'b1;
    @(negedge clk26m);
    div_wr   = 1'b0;
  endtask

  // Divisor model: tick k lands at cumulative period sum after the enabling edge
  task automatic model(input int intv, input int frac, input int base, input int n,
                       input bit tx, input bit rx);
    int t, facc, k, eff, c;
    t = 0; facc = 0; k = 0;
    eff = (intv < 2) ? 2 : intv;
    while (1) begin
      c = ((facc + frac) >= (1 << FRAC_W)) ? 1 : 0;
      t = t + eff + c;
      facc = (facc + frac) % (1 << FRAC_W);
      k++;
      if (t > n - 1) break;
      if (tx && (k % OSR) == 0)       exp_q.push_back({2'd0, 32'(base + t)});
      if (rx && (k % OSR) == OSR / 2) exp_q.push_back({2'd1, 32'(base + t)});
      if (rx)                         exp_q.push_back({2'd2, 32'(base + t)});
    end
  endtask

  task automatic test_reset;
    #3 rstn = 1'b0;
    #2;
    n_checks++; if (tx_bpsclk !== 1'b0) $display("FAIL reset tx_bpsclk: got %b expected 0", tx_bpsclk); else n_pass++;
    n_checks++; if (rx_bpsclk !== 1'b0) $display("FAIL reset rx_bpsclk: got %b expected 0", rx_bpsclk); else n_pass++;
    n_checks++; if (rx_os_tick !== 1'b0) $display("FAIL reset rx_os_tick: got %b expected 0", rx_os_tick); else n_pass++;
    n_checks++; if (div_busy !== 1'b0) $display("FAIL reset div_busy: got %b expected 0", div_busy); else n_pass++;
    repeat (2) @(negedge clk26m);
    rstn = 1'b1;
    repeat (2) @(negedge clk26m);
    n_checks++; if (div_busy !== 1'b0) $display("FAIL post_reset div_busy: got %b expected 0", div_busy); else n_pass++;
  endtask

  task automatic test_int_div;
    int base; ev_t e, o;
    write_div(4, 0);
    n_checks++; if (div_busy !== 1'b0) $display("FAIL int_div idle write busy: got %b expected 0", div_busy); else n_pass++;
    exp_q.delete(); obs_q.delete();
    @(negedge clk26m); base = cyc + 1; tx_bps_en = 1'b1;
    model(4, 0, base, 260, 1'b1, 1'b0);
    goto(base + 259); tx_bps_en = 1'b0;
    repeat (3) @(negedge clk26m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = {2'd3, 32'd0};
      if (o !== e) $display("FAIL int_div event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d (base %0d)", o.kind, o.cyc, e.kind, e.cyc, base);
      else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL int_div extra events: got %0d, expected 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_frac;
    int base; ev_t e, o;
    write_div(4, 8);
    exp_q.delete(); obs_q.delete();
    @(negedge clk26m); base = cyc + 1; rx_bps_en = 1'b1;
    model(4, 8, base, 190, 1'b0, 1'b1);
    goto(base + 189); rx_bps_en = 1'b0;
    repeat (3) @(negedge clk26m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = {2'd3, 32'd0};
      if (o !== e) $display("FAIL frac event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d (base %0d)", o.kind, o.cyc, e.kind, e.cyc, base);
      else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL frac extra events: got %0d, expected 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_busy_defer;
    int base; ev_t e, o;
    write_div(4, 0);
    exp_q.delete(); obs_q.delete();
    @(negedge clk26m); base = cyc + 1; tx_bps_en = 1'b1;
    model(4, 0, base, 200, 1'b1, 1'b0);
    goto(base + 99);
    div_int = DIV_W'(10); div_frac = '0; div_wr = 1'b1;
    @(negedge clk26m); div_wr = 1'b0;
    n_checks++; if (div_busy !== 1'b1) $display("FAIL busy set: got %b expected 1", div_busy); else n_pass++;
    goto(base + 199);
    n_checks++; if (div_busy !== 1'b1) $display("FAIL busy held while running: got %b expected 1", div_busy); else n_pass++;
    tx_bps_en = 1'b0;
    @(negedge clk26m);
    n_checks++; if (div_busy !== 1'b0) $display("FAIL busy cleared on idle: got %b expected 0", div_busy); else n_pass++;
    @(negedge clk26m); base = cyc + 1; tx_bps_en = 1'b1;
    model(10, 0, base, 330, 1'b1, 1'b0);
    goto(base + 329); tx_bps_en = 1'b0;
    repeat (3) @(negedge clk26m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = {2'd3, 32'd0};
      if (o !== e) $display("FAIL busy_defer event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", o.kind, o.cyc, e.kind, e.cyc);
      else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL busy_defer extra events: got %0d, expected 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_clamp;
    int base; ev_t e, o;
    for (int d = 0; d < 2; d++) begin
      write_div(d, 0);
      exp_q.delete(); obs_q.delete();
      @(negedge clk26m); base = cyc + 1; tx_bps_en = 1'b1;
      model(d, 0, base, 70, 1'b1, 1'b0);
      goto(base + 69); tx_bps_en = 1'b0;
      repeat (3) @(negedge clk26m);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_checks++;
        if (obs_q.size() > 0) o = obs_q.pop_front(); else o = {2'd3, 32'd0};
        if (o !== e) $display("FAIL clamp div %0d event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", d, o.kind, o.cyc, e.kind, e.cyc);
        else n_pass++;
      end
      n_checks++; if (obs_q.size() != 0) $display("FAIL clamp div %0d extra events: got %0d, expected 0", d, obs_q.size()); else n_pass++;
    end
  endtask

  task automatic test_rejoin;
    int base; ev_t e, o;
    write_div(4, 0);
    exp_q.delete(); obs_q.delete();
    @(negedge clk26m); base = cyc + 1; tx_bps_en = 1'b1; rx_bps_en = 1'b1;
    // rx off for edges base+98..101; ticks every 4 cycles keep running for tx
    for (int t = 4; t <= 269; t += 4) begin
      if (t % 64 == 0) exp_q.push_back({2'd0, 32'(base + t)});
      if (t == 32 || t == 96 || t == 132 || t == 196 || t == 260) exp_q.push_back({2'd1, 32'(base + t)});
      if (t <= 96 || t >= 104) exp_q.push_back({2'd2, 32'(base + t)});
    end
    goto(base + 97);  rx_bps_en = 1'b0;
    goto(base + 101); rx_bps_en = 1'b1;
    goto(base + 269); tx_bps_en = 1'b0; rx_bps_en = 1'b0;
    repeat (3) @(negedge clk26m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = {2'd3, 32'd0};
      if (o !== e) $display("FAIL rejoin event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d (base %0d)", o.kind, o.cyc, e.kind, e.cyc, base);
      else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL rejoin extra events: got %0d, expected 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int base; ev_t e, o;
    write_div(4, 0);
    @(negedge clk26m); tx_bps_en = 1'b1;
    repeat (20) @(negedge clk26m);
    div_int = DIV_W'(10); div_wr = 1'b1;
    @(negedge clk26m); div_wr = 1'b0;
    n_checks++; if (div_busy !== 1'b1) $display("FAIL reset_mid pending: got %b expected 1", div_busy); else n_pass++;
    for (int i = 0; i < 200 && !tx_bpsclk; i++) @(negedge clk26m);
    n_checks++; if (tx_bpsclk !== 1'b1) $display("FAIL reset_mid wait tx_bpsclk: got %b expected 1 within 200 cycles", tx_bpsclk); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (tx_bpsclk !== 1'b0) $display("FAIL reset_mid async tx_bpsclk: got %b expected 0", tx_bpsclk); else n_pass++;
    n_checks++; if (div_busy !== 1'b0) $display("FAIL reset_mid async div_busy: got %b expected 0", div_busy); else n_pass++;
    @(negedge clk26m); tx_bps_en = 1'b0;
    repeat (2) @(negedge clk26m);
    rstn = 1'b1;
    exp_q.delete(); obs_q.delete();
    @(negedge clk26m);
    n_checks++; if (div_busy !== 1'b0) $display("FAIL reset_mid lost pending: got %b expected 0", div_busy); else n_pass++;
    base = cyc + 1; tx_bps_en = 1'b1;
    model(339, 0, base, 10860, 1'b1, 1'b0);
    goto(base + 10859); tx_bps_en = 1'b0;
    repeat (3) @(negedge clk26m);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = {2'd3, 32'd0};
      if (o !== e) $display("FAIL reset_mid event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d (base %0d)", o.kind, o.cyc, e.kind, e.cyc, base);
      else n_pass++;
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL reset_mid extra events: got %0d, expected 0", obs_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_int_div;
    test_frac;
    test_busy_defer;
    test_clamp;
    test_rejoin;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
